// File: rtl/ad_ip_jesd204_tpl_adc_pn_monitor.sv
// Per-channel PN9/PN23 checker for the ADC transport layer.
// Self-synchronising: each bit is predicted from previously received bits.
module ad_ip_jesd204_tpl_adc_pn_monitor #(
    parameter int DATA_PATH_WIDTH = 1,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                                    link_clk,
    input  logic                                    adc_rst,
    input  logic                                    data_valid,
    input  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] data,
    input  logic [3:0]                              pn_seq_sel,
    output logic                                    pn_err,
    output logic                                    pn_oos
);

    localparam int W  = DATA_PATH_WIDTH * SAMPLE_WIDTH;
    localparam int HW = 32;
    localparam logic [7:0] SKIP_PN9  = 8'((9 + W - 1) / W);
    localparam logic [7:0] SKIP_PN23 = 8'((23 + W - 1) / W);
    localparam logic [7:0] TH        = 8'(OOS_THRESHOLD);

    typedef enum logic {
        ST_OOS  = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    // Stream bit i (arrival order) lives at this data index: sample 0 first, MSB first.
    function automatic int bit_idx(input int i);
        return (i / SAMPLE_WIDTH) * SAMPLE_WIDTH + (SAMPLE_WIDTH - 1 - (i % SAMPLE_WIDTH));
    endfunction

    logic [3:0]    r_sel_prev;
    logic          r_v0, r_v1, r_v2, r_m2;
    logic [W-1:0]  r_d0, r_d1, r_p1;
    logic [HW-1:0] r_hist;
    logic [7:0]    r_warm;
    state_t        r_state;
    logic [7:0]    r_cnt;

    logic          w_sel_chg, w_en, w_is23;
    logic [7:0]    w_need, w_cnt_inc;
    logic [W+HW-1:0] w_ext;
    logic [W-1:0]  w_pred;
    logic [HW-1:0] w_hist_nxt;
    state_t        w_state_nxt;
    logic [7:0]    w_cnt_nxt;
    logic          w_err_nxt, w_oos_nxt;

    assign w_sel_chg = (pn_seq_sel != r_sel_prev);
    assign w_en      = (pn_seq_sel == 4'd0) || (pn_seq_sel == 4'd1);
    assign w_is23    = (pn_seq_sel == 4'd1);
    assign w_need    = w_is23 ? SKIP_PN23 : SKIP_PN9;
    assign w_cnt_inc = (r_cnt >= TH) ? TH : (r_cnt + 8'd1);

    // Parallel prediction: w_ext holds history above the beat's bits, newest bit lowest.
    always_comb begin
        w_ext  = {r_hist, {W{1'b0}}};
        w_pred = '0;
        for (int i = 0; i < W; i++) begin
            w_ext[W-1-i] = r_d0[bit_idx(i)];
        end
        for (int i = 0; i < W; i++) begin
            if (w_is23) begin
                w_pred[bit_idx(i)] = w_ext[W-1-i+23] ^ w_ext[W-1-i+18];
            end else begin
                w_pred[bit_idx(i)] = w_ext[W-1-i+9] ^ w_ext[W-1-i+5];
            end
        end
        w_hist_nxt = w_ext[HW-1:0];
    end

    // Input capture, history/warm-up and the two compare stages.
    always_ff @(posedge link_clk or posedge adc_rst) begin
        if (adc_rst) begin
            r_sel_prev <= 4'd0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_m2       <= 1'b0;
            r_d0       <= '0;
            r_d1       <= '0;
            r_p1       <= '0;
            r_hist     <= '0;
            r_warm     <= 8'd0;
        end else begin
            r_sel_prev <= pn_seq_sel;
            r_v0       <= data_valid;
            r_d0       <= data;
            if (w_sel_chg) begin
                r_v1   <= 1'b0;
                r_v2   <= 1'b0;
                r_hist <= '0;
                r_warm <= 8'd0;
            end else begin
                r_v2 <= r_v1;
                r_m2 <= (r_d1 == r_p1) && (r_d1 != '0);
                if (r_v0 && w_en) begin
                    r_hist <= w_hist_nxt;
                    r_d1   <= r_d0;
                    r_p1   <= w_pred;
                    if (r_warm < w_need) begin
                        r_warm <= r_warm + 8'd1;
                        r_v1   <= 1'b0;
                    end else begin
                        r_v1   <= 1'b1;
                    end
                end else begin
                    r_v1 <= 1'b0;
                end
            end
        end
    end

    // Lock state machine: next state, counter and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_oos_nxt   = pn_oos;
        if (w_sel_chg || !w_en) begin
            w_state_nxt = ST_OOS;
            w_cnt_nxt   = 8'd0;
            w_oos_nxt   = 1'b1;
        end else if (r_v2) begin
            case (r_state)
                ST_OOS: begin
                    if (r_m2) begin
                        if (w_cnt_inc == TH) begin
                            w_state_nxt = ST_SYNC;
                            w_cnt_nxt   = 8'd0;
                            w_oos_nxt   = 1'b0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = 8'd0;
                    end
                end
                ST_SYNC: begin
                    if (!r_m2) begin
                        w_err_nxt = 1'b1;
                        if (w_cnt_inc == TH) begin
                            w_state_nxt = ST_OOS;
                            w_cnt_nxt   = 8'd0;
                            w_oos_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_OOS;
                    w_cnt_nxt   = 8'd0;
                    w_oos_nxt   = 1'b1;
                end
            endcase
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Status register.
    always_ff @(posedge link_clk or posedge adc_rst) begin
        if (adc_rst) begin
            r_state <= ST_OOS;
            r_cnt   <= 8'd0;
            pn_err  <= 1'b0;
            pn_oos  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            pn_err  <= w_err_nxt;
            pn_oos  <= w_oos_nxt;
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_monitor.sv
// Bench for the PN monitor: bit-serial reference model with a 3-beat output delay line.
module tb_ad_ip_jesd204_tpl_adc_pn_monitor;

    localparam int DPW = 1;
    localparam int SW  = 16;
    localparam int W   = DPW * SW;
    localparam int TH  = 16;

    logic         link_clk = 1'b0;
    logic         adc_rst  = 1'b1;
    logic         data_valid = 1'b0;
    logic [W-1:0] data = '0;
    logic [3:0]   pn_seq_sel = 4'd0;
    logic         pn_err, pn_oos;

    ad_ip_jesd204_tpl_adc_pn_monitor #(
        .DATA_PATH_WIDTH(DPW), .SAMPLE_WIDTH(SW), .OOS_THRESHOLD(TH)
    ) dut (
        .link_clk(link_clk), .adc_rst(adc_rst), .data_valid(data_valid),
        .data(data), .pn_seq_sel(pn_seq_sel), .pn_err(pn_err), .pn_oos(pn_oos)
    );

    always #5 link_clk = ~link_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sel = 4'd0;
    bit         gen[$];
    bit         rx[$];
    int         m_warm, m_cnt;
    bit         m_sync;
    logic [3:0] m_prev_sel;
    logic [1:0] exp_q[$];   // {pn_err, pn_oos} expected for the next three edges

    function automatic int didx(input int i);
        return (i / SW) * SW + (SW - 1 - (i % SW));
    endfunction

    // Next beat of a PN stream seeded with all ones.
    task automatic pn_beat(input int l, input int t, output logic [W-1:0] d);
        bit b;
        int n;
        d = '0;
        for (int i = 0; i < W; i++) begin
            n = gen.size();
            b = (n < l) ? 1'b1 : (gen[n-l] ^ gen[n-t]);
            gen.push_back(b);
            d[didx(i)] = b;
        end
        while (gen.size() > 64) void'(gen.pop_front());
    endtask

    task automatic model_clear();
        rx.delete();
        m_warm = 0;
        m_cnt  = 0;
        m_sync = 1'b0;
    endtask

    task automatic model_beat(input logic v, input logic [W-1:0] d, output logic [1:0] res);
        int  l, t, need, n;
        bit  mism, b, p, err;
        if (sel !== m_prev_sel) begin
            for (int k = 0; k < exp_q.size(); k++) exp_q[k] = 2'b01;
            model_clear();
            m_prev_sel = sel;
        end
        if (!(sel == 4'd0 || sel == 4'd1)) begin
            res = 2'b01;
        end else if (!v) begin
            res = {1'b0, !m_sync};
        end else begin
            l    = (sel == 4'd1) ? 23 : 9;
            t    = (sel == 4'd1) ? 18 : 5;
            need = (l + W - 1) / W;
            mism = (d == '0);
            for (int i = 0; i < W; i++) begin
                b = d[didx(i)];
                n = rx.size();
                if (m_warm >= need) begin
                    p = rx[n-l] ^ rx[n-t];
                    if (p != b) mism = 1'b1;
                end
                rx.push_back(b);
            end
            while (rx.size() > 64) void'(rx.pop_front());
            err = 1'b0;
            if (m_warm < need) begin
                m_warm++;
            end else if (!m_sync) begin
                if (mism) m_cnt = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == TH) begin m_sync = 1'b1; m_cnt = 0; end
                end
            end else begin
                if (mism) begin
                    err = 1'b1;
                    m_cnt++;
                    if (m_cnt == TH) begin m_sync = 1'b0; m_cnt = 0; end
                end else m_cnt = 0;
            end
            res = {err, !m_sync};
        end
    endtask

    // Drive one cycle, advance the model, return observed and expected status after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, output logic [1:0] obs, output logic [1:0] ex);
        logic [1:0] r;
        @(negedge link_clk);
        pn_seq_sel = sel;
        data_valid = v;
        data       = d;
        model_beat(v, d, r);
        exp_q.push_back(r);
        @(posedge link_clk);
        #1;
        ex  = exp_q.pop_front();
        obs = {pn_err, pn_oos};
    endtask

    // Asynchronous reset pulse; returns the status seen before any clock edge.
    task automatic do_reset(output logic [1:0] obs_async);
        @(negedge link_clk);
        #2;
        adc_rst    = 1'b1;
        data_valid = 1'b0;
        pn_seq_sel = sel;
        #1;
        obs_async = {pn_err, pn_oos};
        model_clear();
        m_prev_sel = sel;
        exp_q.delete();
        repeat (3) exp_q.push_back(2'b01);
        repeat (2) @(posedge link_clk);
        @(negedge link_clk);
        adc_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] obs, ex;
        sel = 4'd0;
        do_reset(obs);
        n_checks++;
        if (obs !== 2'b01) begin n_fail++; $display("FAIL reset_async: err/oos got %b expected 01", obs); end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, W'($urandom), obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %b expected %b", k, obs, ex); end
        end
    endtask

    task automatic test_pn9_lock();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int first_lock = -1, errs = 0;
        sel = 4'd0;
        do_reset(obs);
        gen.delete();
        for (int k = 1; k <= 40; k++) begin
            pn_beat(9, 5, d);
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL pn9_lock beat %0d: got %b expected %b", k, obs, ex); end
            if (obs[0] == 1'b0 && first_lock < 0) first_lock = k;
            errs += int'(obs[1]);
        end
        // Warm-up 1 beat + 16 matches = beat 17, seen 3 cycles later.
        n_checks++;
        if (first_lock != 20) begin n_fail++; $display("FAIL pn9_lock_time: got cycle %0d expected 20", first_lock); end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL pn9_no_err: got %0d pulses expected 0", errs); end
    endtask

    task automatic test_pn23_flip();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int errs = 0, exp_errs = 0, oos_hi = 0;
        sel = 4'd1;
        do_reset(obs);
        gen.delete();
        for (int k = 0; k < 75; k++) begin
            pn_beat(23, 18, d);
            if (k == 50) d = d ^ 16'h0400;   // stream bit 5 of this beat
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL pn23_flip beat %0d: got %b expected %b", k, obs, ex); end
            if (k >= 40) begin
                errs     += int'(obs[1]);
                exp_errs += int'(ex[1]);
                oos_hi   += int'(obs[0]);
            end
        end
        n_checks++;
        if (errs != exp_errs || errs != 2) begin n_fail++; $display("FAIL pn23_err_count: got %0d expected %0d (2)", errs, exp_errs); end
        n_checks++;
        if (oos_hi != 0) begin n_fail++; $display("FAIL pn23_oos_held: got %0d oos cycles expected 0", oos_hi); end
    endtask

    task automatic test_pn9_burst();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int errs = 0, exp_errs = 0;
        bit saw_oos = 1'b0;
        sel = 4'd0;
        do_reset(obs);
        gen.delete();
        for (int k = 0; k < 86; k++) begin
            if (k >= 30 && k < 46) d = W'($urandom);
            else pn_beat(9, 5, d);
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL pn9_burst beat %0d: got %b expected %b", k, obs, ex); end
            if (k >= 30) begin
                errs     += int'(obs[1]);
                exp_errs += int'(ex[1]);
                if (obs[0]) saw_oos = 1'b1;
            end
        end
        n_checks++;
        if (errs != exp_errs) begin n_fail++; $display("FAIL pn9_burst_errs: got %0d expected %0d", errs, exp_errs); end
        n_checks++;
        if (!saw_oos || obs[0] !== 1'b0) begin n_fail++; $display("FAIL pn9_burst_relock: saw_oos %0b final oos %b expected 1/0", saw_oos, obs[0]); end
    endtask

    task automatic test_zero();
        logic [1:0] obs, ex;
        int bad = 0;
        sel = 4'd0;
        do_reset(obs);
        for (int k = 0; k < 100; k++) begin
            step(1'b1, '0, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL zero beat %0d: got %b expected %b", k, obs, ex); end
            if (obs !== 2'b01) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL zero_never_lock: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_sel_switch();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int errs = 0, locks = 0;
        sel = 4'd0;
        do_reset(obs);
        gen.delete();
        for (int k = 0; k < 90; k++) begin
            if (k == 30) sel = 4'd1;
            pn_beat(9, 5, d);
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL sel_switch beat %0d: got %b expected %b", k, obs, ex); end
            if (k == 29) begin
                n_checks++;
                if (obs !== 2'b00) begin n_fail++; $display("FAIL sel_switch_prelock: got %b expected 00", obs); end
            end
            if (k == 30) begin
                n_checks++;
                if (obs !== 2'b01) begin n_fail++; $display("FAIL sel_switch_1cyc: got %b expected 01", obs); end
            end
            if (k >= 30) begin
                errs  += int'(obs[1]);
                locks += int'(!obs[0]);
            end
        end
        n_checks++;
        if (errs != 0 || locks != 0) begin n_fail++; $display("FAIL sel_switch_quiet: got err %0d lock %0d expected 0 0", errs, locks); end
    endtask

    task automatic test_gaps_reset();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int first_lock = -1;
        sel = 4'd0;
        do_reset(obs);
        gen.delete();
        for (int k = 0; k < 80; k++) begin
            if (k % 2 == 0) pn_beat(9, 5, d);
            else d = W'($urandom);
            step(k % 2 == 0, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL gaps beat %0d: got %b expected %b", k, obs, ex); end
        end
        n_checks++;
        if (obs !== 2'b00) begin n_fail++; $display("FAIL gaps_locked: got %b expected 00", obs); end
        do_reset(obs);
        n_checks++;
        if (obs !== 2'b01) begin n_fail++; $display("FAIL midstream_reset_async: got %b expected 01", obs); end
        for (int k = 1; k <= 30; k++) begin
            pn_beat(9, 5, d);
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL post_reset beat %0d: got %b expected %b", k, obs, ex); end
            if (obs[0] == 1'b0 && first_lock < 0) first_lock = k;
        end
        n_checks++;
        if (first_lock != 20) begin n_fail++; $display("FAIL post_reset_relock: got cycle %0d expected 20", first_lock); end
    endtask

    task automatic test_disabled();
        logic [1:0] obs, ex;
        logic [W-1:0] d;
        int bad = 0;
        sel = 4'd5;
        do_reset(obs);
        gen.delete();
        for (int k = 0; k < 40; k++) begin
            pn_beat(9, 5, d);
            step(1'b1, d, obs, ex);
            n_checks++;
            if (obs !== ex) begin n_fail++; $display("FAIL disabled beat %0d: got %b expected %b", k, obs, ex); end
            if (obs !== 2'b01) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL disabled_held: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        m_prev_sel = 4'd0;
        test_reset();
        test_pn9_lock();
        test_pn23_flip();
        test_pn9_burst();
        test_zero();
        test_sel_switch();
        test_gaps_reset();
        test_disabled();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
